// File: rtl/sram_frame_reader.sv
// Streams a block of SRAM words out of one arbiter read port as an 8-bit pixel stream.
// Word requests are credit-limited so every returned word has a buffer slot waiting for it.
module sram_frame_reader #(
    parameter int unsigned ADDR_WIDTH      = 18,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_addr_valid,
    input  logic                  rd_addr_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_data_valid,
    output logic                  rd_data_ready,
    input  logic [31:0]           rd_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [7:0]            pix,
    output logic                  pix_last
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CRD_W = PTR_W + 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      emitted_q, emitted_d;
    logic [CRD_W-1:0]      credits_q, credits_d;
    logic [CRD_W-1:0]      fill_q, fill_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0]            byte_q, byte_d;
    logic [31:0]           mem [MAX_OUTSTANDING];

    logic        active;
    logic        issue_fire;
    logic        wr_en;
    logic        pix_fire;
    logic        pop;
    logic [31:0] head_word;

    assign active        = (state_q == ISSUE) || (state_q == DRAIN);
    assign busy          = active;
    assign done          = (state_q == FIN);
    assign rd_addr_valid = (state_q == ISSUE) && (credits_q < CRD_W'(MAX_OUTSTANDING));
    assign issue_fire    = rd_addr_valid && rd_addr_ready;
    assign rd_addr       = base_q + issued_q[ADDR_WIDTH-1:0];
    assign rd_data_ready = 1'b1;
    // Words landing outside a job are popped from the arbiter and dropped.
    assign wr_en         = rd_data_valid && active;

    assign head_word = mem[rd_ptr_q];
    assign pix_valid = active && (fill_q != '0);
    assign pix       = pix_valid ? head_word[{byte_q, 3'b000} +: 8] : 8'd0;
    assign pix_last  = pix_valid && (byte_q == 2'd3) && (emitted_q == num_q - CNT_W'(1));
    assign pix_fire  = pix_valid && pix_ready;
    assign pop       = pix_fire && (byte_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        issued_d  = issue_fire ? issued_q + CNT_W'(1) : issued_q;
        emitted_d = pop ? emitted_q + CNT_W'(1) : emitted_q;
        byte_d    = pix_fire ? byte_q + 2'd1 : byte_q;
        credits_d = credits_q + CRD_W'(issue_fire) - CRD_W'(pop);
        fill_d    = fill_q + CRD_W'(wr_en) - CRD_W'(pop);
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = {1'b0, num_words};
                    issued_d  = '0;
                    emitted_d = '0;
                    byte_d    = 2'd0;
                    credits_d = '0;
                    fill_d    = '0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    state_d   = (num_words != '0) ? ISSUE : FIN;
                end
            end
            ISSUE: begin
                if (issue_fire && (issued_q + CNT_W'(1) == num_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pix_fire && pix_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            emitted_q <= '0;
            credits_q <= '0;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            byte_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            emitted_q <= emitted_d;
            credits_q <= credits_d;
            fill_q    <= fill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            byte_q    <= byte_d;
        end
    end

    // Storage needs no reset: fill_q gates every read of it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rd_data;
        end
    end

endmodule

// File: tb/tb_sram_frame_reader.sv
// Scoreboard bench for sram_frame_reader: an arbiter/SRAM model answers requests,
// expected addresses and pixels are queued at stimulus time and popped by a monitor.
module tb_sram_frame_reader;

    localparam int AW = 18;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_words = '0;
    logic          busy;
    logic          done;
    logic          rd_addr_valid;
    logic          rd_addr_ready = 1'b1;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid = 1'b0;
    logic          rd_data_ready;
    logic [31:0]   rd_data = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [7:0]    pix;
    logic          pix_last;

    sram_frame_reader #(
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .rd_addr_valid (rd_addr_valid),
        .rd_addr_ready (rd_addr_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix           (pix),
        .pix_last      (pix_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          due;
    } ret_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            pix_mode = 0;   // 0 always ready, 1 never ready, 2 random
    int            addr_mode = 0;  // 0 always ready, 1 ready one cycle in three
    int            issue_cnt = 0;
    logic [AW-1:0] exp_addr[$];
    logic [8:0]    exp_pix[$];
    ret_t          rdq[$];
    bit            exp_done_next = 1'b0;
    bit            zero_flag = 1'b0;
    bit            prev_av = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    bit            prev_pv = 1'b0;
    logic [8:0]    prev_pix = '0;

    localparam logic [63:0] RESET_VEC = {31'd0, 1'b0, 1'b0, 1'b0, 18'd0, 1'b1, 1'b0, 8'd0, 1'b0};

    function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
        if (a == 18'h00010) return 32'h44332211;
        if (a == 18'h00011) return 32'h88776655;
        return ({14'd0, a} * 32'h01000193) ^ 32'h9E3779B9;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [63:0] out_vec();
        return {31'd0, busy, done, rd_addr_valid, rd_addr, rd_data_ready, pix_valid, pix, pix_last};
    endfunction

    task automatic push_word(input logic [AW-1:0] a, input bit last_word);
        logic [31:0] w;
        w = sram_word(a);
        exp_addr.push_back(a);
        for (int b = 0; b < 4; b++) begin
            exp_pix.push_back({last_word && (b == 3), w[8*b +: 8]});
        end
    endtask

    task automatic push_job(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_word(base + AW'(i), i == n - 1);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW-1:0] n);
        @(posedge clock);
        #1;
        start = 1'b1;
        base_addr = base;
        num_words = n;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) break;
        end
        check({name, "_done"}, done, 1);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_addr_left"}, exp_addr.size(), 0);
        check({name, "_pix_left"}, exp_pix.size(), 0);
    endtask

    // Arbiter/SRAM model: drives handshakes after each edge, returns data two cycles later.
    always @(posedge clock) begin
        #1;
        cyc++;
        rd_addr_ready = (addr_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        case (pix_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'b0;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        if (!reset_n) begin
            rdq.delete();
            rd_data_valid = 1'b0;
        end else begin
            if (rd_data_valid && rdq.size() > 0) rdq.delete(0);
            if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                rd_data_valid = 1'b1;
                rd_data = rdq[0].data;
            end else begin
                rd_data_valid = 1'b0;
            end
        end
    end

    // Monitor: checks handshakes, stall stability and done timing against the queues.
    always @(negedge clock) begin
        ret_t r;
        if (!reset_n) begin
            prev_av = 1'b0;
            prev_pv = 1'b0;
            exp_done_next = 1'b0;
        end else begin
            if (exp_done_next || done) check("done_pulse", done, exp_done_next);
            exp_done_next = 1'b0;
            if (zero_flag) begin
                exp_done_next = 1'b1;
                zero_flag = 1'b0;
            end
            if (rd_data_valid) check("rd_data_ready", rd_data_ready, 1);
            if (prev_av) begin
                check("addr_hold_valid", rd_addr_valid, 1);
                check("addr_hold_value", rd_addr, prev_addr);
            end
            if (rd_addr_valid && rd_addr_ready) begin
                issue_cnt++;
                if (exp_addr.size() == 0) begin
                    flag("unexpected_rd_addr");
                end else begin
                    check("rd_addr", rd_addr, exp_addr[0]);
                    exp_addr.delete(0);
                end
                r.data = sram_word(rd_addr);
                r.due = cyc + 2;
                rdq.push_back(r);
            end
            prev_av = rd_addr_valid && !rd_addr_ready;
            prev_addr = rd_addr;
            if (prev_pv) begin
                check("pix_hold_valid", pix_valid, 1);
                check("pix_hold_value", {pix_last, pix}, prev_pix);
            end
            if (pix_valid && pix_ready) begin
                if (exp_pix.size() == 0) begin
                    flag("unexpected_pixel");
                end else begin
                    check("pixel", {pix_last, pix}, exp_pix[0]);
                    exp_pix.delete(0);
                end
                if (pix_last) exp_done_next = 1'b1;
            end
            prev_pv = pix_valid && !pix_ready;
            prev_pix = {pix_last, pix};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", out_vec(), RESET_VEC);
        reset_n = 1'b1;

        // 1: two words, full-rate handshakes, hand-computed pixel stream.
        exp_addr.push_back(18'h00010);
        exp_addr.push_back(18'h00011);
        exp_pix.push_back(9'h011);
        exp_pix.push_back(9'h022);
        exp_pix.push_back(9'h033);
        exp_pix.push_back(9'h044);
        exp_pix.push_back(9'h055);
        exp_pix.push_back(9'h066);
        exp_pix.push_back(9'h077);
        exp_pix.push_back(9'h188);
        @(posedge clock);
        #1;
        start = 1'b1;
        base_addr = 18'h00010;
        num_words = 18'd2;
        @(negedge clock);
        check("t1_no_req_in_start_cycle", rd_addr_valid, 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("t1_req_cycle_after_start", rd_addr_valid, 1);
        check("t1_busy", busy, 1);
        wait_done("t1", 200);

        // 2: address wrap past the top of SRAM.
        push_word(18'h3FFFE, 1'b0);
        push_word(18'h3FFFF, 1'b0);
        push_word(18'h00000, 1'b0);
        push_word(18'h00001, 1'b1);
        pulse_start(18'h3FFFE, 18'd4);
        wait_done("t2", 200);

        // 3: downstream stalled -> credits cap requests at 8.
        pix_mode = 1;
        push_job(18'h00100, 32);
        issue_cnt = 0;
        pulse_start(18'h00100, 18'd32);
        repeat (40) @(negedge clock);
        check("t3_credit_limit", issue_cnt, 8);
        check("t3_addr_valid_low", rd_addr_valid, 0);
        check("t3_pix_valid_held", pix_valid, 1);
        pix_mode = 0;
        wait_done("t3", 1000);

        // 4: request port stalls two cycles in three, random pixel backpressure.
        addr_mode = 1;
        pix_mode = 2;
        push_job(18'h02345, 12);
        pulse_start(18'h02345, 18'd12);
        wait_done("t4", 2000);
        addr_mode = 0;
        pix_mode = 0;

        // 5a: empty job.
        @(posedge clock);
        #1;
        start = 1'b1;
        base_addr = 18'h00005;
        num_words = 18'd0;
        zero_flag = 1'b1;
        @(negedge clock);
        check("t5_zero_no_req", rd_addr_valid, 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("t5_zero_no_req_fin", rd_addr_valid, 0);
        check("t5_zero_no_pix", pix_valid, 0);
        check("t5_zero_not_busy", busy, 0);
        repeat (3) @(negedge clock);

        // 5b: start while busy is ignored.
        push_job(18'h00040, 3);
        pulse_start(18'h00040, 18'd3);
        @(posedge clock);
        #1;
        start = 1'b1;
        base_addr = 18'h03000;
        num_words = 18'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("t5b", 300);
        repeat (10) @(negedge clock);
        check("t5b_no_extra_job", {busy, rd_addr_valid}, 2'b00);

        // 6: reset while draining, then a clean job.
        pix_mode = 1;
        push_job(18'h00500, 4);
        pulse_start(18'h00500, 18'd4);
        repeat (20) @(negedge clock);
        check("t6_in_drain", {busy, rd_addr_valid, pix_valid}, 3'b101);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", out_vec(), RESET_VEC);
        exp_addr.delete();
        exp_pix.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        pix_mode = 0;
        push_job(18'h00600, 2);
        pulse_start(18'h00600, 18'd2);
        wait_done("t6", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
